// File: rtl/rf_timing_pkg.sv
// ---------------------------------------------------------------------------
// rf_timing_pkg
// Shared definitions for the RF pulse-train generator:
//   - state_t        : frame sequencer states
//   - RST_GAP_DEF    : default cycles from rf_out fall to the fsm_rst strobe
//   - MIN_PERIOD_DEF : default smallest legal frame period
//   - CLK_PERIOD_NS  : nominal clk cycle time (10 MHz clock)
// ---------------------------------------------------------------------------
package rf_timing_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DELAY    = 3'd1,
    S_HIGH     = 3'd2,
    S_GAP      = 3'd3,
    S_WAIT_END = 3'd4
  } state_t;

  localparam int RST_GAP_DEF    = 4;
  localparam int MIN_PERIOD_DEF = 4;
  localparam int CLK_PERIOD_NS  = 100;

endpackage

// File: rtl/rf_frame_cnt.sv
// ---------------------------------------------------------------------------
// rf_frame_cnt
// Loadable CNT_W-bit up-counter with a terminal-count flag.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (count -> 0)
//   load       : load load_val on the next edge (wins over inc)
//   load_val   : value to load
//   inc        : increment on the next edge
//   term       : terminal value; tc is high while the count equals it
//   cnt_next   : combinational next count, used by the parent to decode
//                registered outputs aligned with the count
//   tc         : terminal-count flag for the current count
// ---------------------------------------------------------------------------
module rf_frame_cnt #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt_next,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (inc) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc = (cnt_reg == term);

endmodule

// File: rtl/rf_pulse_gen.sv
// ---------------------------------------------------------------------------
// rf_pulse_gen
// Programmable periodic RF pulse-train generator feeding fsm_sync.
// Each frame is len cycles long; rf_out is high for cnt in [D, D+H-1],
// fsm_rst strobes at cnt == D+H+RST_GAP, sh_en strobes at cnt == len/2.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : run frames while high (sampled at idle and at frame end)
//   period      : frame length P in cycles
//   delay       : cycles from frame start to rf_out rise (D)
//   high        : rf_out high time (H)
//   rf_out      : RF pulse (registered, glitch-free)
//   fsm_rst     : one-cycle strobe after the pulse
//   sh_en       : one-cycle mid-frame strobe
//   frame_start : one-cycle strobe at cnt 0
//   busy        : a frame is in progress
//   cfg_err     : config of the current/last frame was illegal
// All outputs are flops decoded from the next counter value and the next
// latched config, so every output lines up with the registered count.
// ---------------------------------------------------------------------------
module rf_pulse_gen
  import rf_timing_pkg::*;
#(
  parameter int CNT_W      = 24,
  parameter int RST_GAP    = RST_GAP_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] high,
  output logic             rf_out,
  output logic             fsm_rst,
  output logic             sh_en,
  output logic             frame_start,
  output logic             busy,
  output logic             cfg_err
);

  // Two extra bits so D+H+RST_GAP can never wrap.
  localparam int SW = CNT_W + 2;

  // ---- legality of the config presented on the ports ----
  logic [SW-1:0]    period_w;
  logic [SW-1:0]    need_w;
  logic             in_legal;
  logic [CNT_W-1:0] in_len;

  assign period_w = SW'(period);
  assign need_w   = SW'(delay) + SW'(high) + SW'(RST_GAP);
  // need <= P-1 written as need < P to avoid any subtraction wrap.
  assign in_legal = (period_w >= SW'(MIN_PERIOD)) && (high != '0) && (need_w < period_w);
  assign in_len   = (period_w < SW'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period;

  // ---- latched frame config ----
  logic [CNT_W-1:0] len_reg, delay_reg, high_reg;
  logic             legal_reg;
  state_t           state_reg, state_next;

  // ---- counter ----
  logic             start, stop;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_tc;

  rf_frame_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (start | stop),
    .load_val ('0),
    .inc      (state_reg != S_IDLE),
    .term     (len_reg - CNT_W'(1)),
    .cnt_next (cnt_next),
    .tc       (cnt_tc)
  );

  // A frame starts from idle, or back-to-back when en is high in the last
  // cycle of the current frame; en is otherwise ignored mid-frame.
  always_comb begin
    start = 1'b0;
    stop  = 1'b0;
    if (state_reg == S_IDLE) begin
      start = en;
    end else if (cnt_tc) begin
      start = en;
      stop  = !en;
    end
  end

  // Config that will be in force next cycle.
  logic [CNT_W-1:0] len_n, delay_n, high_n;
  logic             legal_n;
  logic [SW-1:0]    hi_end_n, rst_pt_n, cnt_next_w;

  assign len_n      = start ? in_len   : len_reg;
  assign delay_n    = start ? delay    : delay_reg;
  assign high_n     = start ? high     : high_reg;
  assign legal_n    = start ? in_legal : legal_reg;
  assign hi_end_n   = SW'(delay_n) + SW'(high_n);
  assign rst_pt_n   = hi_end_n + SW'(RST_GAP);
  assign cnt_next_w = SW'(cnt_next);

  logic rf_out_next, fsm_rst_next, sh_en_next, frame_start_next, busy_next, cfg_err_next;

  always_comb begin
    state_next = state_reg;
    if (start) begin
      // Illegal frames only count; nothing is pulsed.
      if (!legal_n) begin
        state_next = S_WAIT_END;
      end else if (delay_n == '0) begin
        state_next = S_HIGH;
      end else begin
        state_next = S_DELAY;
      end
    end else if (stop) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_DELAY: if (cnt_next_w == SW'(delay_n))      state_next = S_HIGH;
        S_HIGH:  if (cnt_next_w == hi_end_n)          state_next = S_GAP;
        S_GAP:   if (cnt_next_w == rst_pt_n + SW'(1)) state_next = S_WAIT_END;
        default: state_next = state_reg;
      endcase
    end

    rf_out_next      = (state_next == S_HIGH);
    fsm_rst_next     = (state_next == S_GAP) && (cnt_next_w == rst_pt_n);
    sh_en_next       = legal_n && (state_next != S_IDLE) && (cnt_next == (len_n >> 1));
    frame_start_next = start;
    busy_next        = (state_next != S_IDLE);
    cfg_err_next     = start ? !in_legal : cfg_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      len_reg   <= '0;
      delay_reg <= '0;
      high_reg  <= '0;
      legal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        len_reg   <= in_len;
        delay_reg <= delay;
        high_reg  <= high;
        legal_reg <= in_legal;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_out      <= 1'b0;
      fsm_rst     <= 1'b0;
      sh_en       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      rf_out      <= rf_out_next;
      fsm_rst     <= fsm_rst_next;
      sh_en       <= sh_en_next;
      frame_start <= frame_start_next;
      busy        <= busy_next;
      cfg_err     <= cfg_err_next;
    end
  end

endmodule

// File: tb/tb_rf_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_rf_pulse_gen
// Self-checking bench for rf_pulse_gen. A frame-level reference model
// (frame position, latched P/D/H, legality) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_rf_pulse_gen;

  localparam int CNT_W   = 24;
  localparam int GAP     = 4;
  localparam int MIN_P   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [CNT_W-1:0] period, delay, high;
  logic             rf_out, fsm_rst, sh_en, frame_start, busy, cfg_err;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit     m_active = 1'b0;
  bit     m_legal  = 1'b0;
  bit     m_err    = 1'b0;
  longint m_pos = 0, m_P = 0, m_len = 0, m_D = 0, m_H = 0;
  int     m_frame = 0;

  rf_pulse_gen #(
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .period      (period),
    .delay       (delay),
    .high        (high),
    .rf_out      (rf_out),
    .fsm_rst     (fsm_rst),
    .sh_en       (sh_en),
    .frame_start (frame_start),
    .busy        (busy),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic model_start();
    m_P      = longint'(period);
    m_len    = (m_P < MIN_P) ? longint'(MIN_P) : m_P;
    m_D      = longint'(delay);
    m_H      = longint'(high);
    m_legal  = (m_P >= MIN_P) && (m_H >= 1) && (m_D + m_H + GAP <= m_P - 1);
    m_err    = !m_legal;
    m_pos    = 0;
    m_active = 1'b1;
    m_frame++;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    if (rst) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_err    = 1'b0;
      m_legal  = 1'b0;
    end else if (m_active && m_pos == m_len - 1) begin
      $display("frame %0d done: P=%0d D=%0d H=%0d legal=%0d len=%0d",
               m_frame, m_P, m_D, m_H, m_legal, m_len);
      if (en) begin
        model_start();
      end else begin
        m_active = 1'b0;
        m_pos    = 0;
      end
    end else if (m_active) begin
      m_pos++;
    end else if (en) begin
      model_start();
    end
  endtask

  function automatic logic [5:0] exp_vec();
    logic fs, bz, rf, fr, sh, er;
    fs = m_active && (m_pos == 0);
    bz = m_active;
    rf = m_active && m_legal && (m_pos >= m_D) && (m_pos < m_D + m_H);
    fr = m_active && m_legal && (m_pos == m_D + m_H + GAP);
    sh = m_active && m_legal && (m_pos == m_len / 2);
    er = m_err;
    return {fs, bz, rf, fr, sh, er};
  endfunction

  task automatic check_outputs(input string tag);
    logic [5:0] obs, exp;
    obs = {frame_start, busy, rf_out, fsm_rst, sh_en, cfg_err};
    exp = exp_vec();
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t frame=%0d pos=%0d obs(fs,busy,rf,frst,sh,err)=%b exp=%b",
             tag, $time, m_frame, m_pos, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("cycle");
  endtask

  task automatic wait_pos(input int frame, input longint pos, input int limit);
    int n = 0;
    while (!(m_active && m_frame == frame && m_pos == pos) && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $error("FAIL wait_pos timeout frame=%0d pos=%0d reached frame=%0d pos=%0d",
             frame, pos, m_frame, m_pos);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (m_active && n < limit) begin
      step();
      n++;
    end
    if (n >= limit) begin
      total++;
      bad++;
      $error("FAIL wait_idle timeout pos=%0d required idle", m_pos);
    end
  endtask

  // One isolated frame with the given config.
  task automatic run_one(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] d,
                         input logic [CNT_W-1:0] h);
    period = p;
    delay  = d;
    high   = h;
    en     = 1'b1;
    step();
    en     = 1'b0;
    wait_idle(200);
    step();
  endtask

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    period = '0;
    delay  = '0;
    high   = '0;
    #1;
    check_outputs("reset_state");
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();

    // 1) P=10000 D=3000 H=1, en held for 3 frames
    period = 24'd10000; delay = 24'd3000; high = 24'd1;
    en = 1'b1; m_frame = 0;
    wait_pos(3, 9999, 40000);
    en = 1'b0;
    wait_idle(10);
    repeat (3) step();

    // 2) same config, en dropped at cnt 4000 of frame 2
    en = 1'b1; m_frame = 0;
    wait_pos(2, 4000, 25000);
    en = 1'b0;
    wait_idle(7000);
    repeat (5) step();

    // 3) illegal P=20 D=14 H=2, then D=10 on the next frame
    period = 24'd20; delay = 24'd14; high = 24'd2;
    en = 1'b1; m_frame = 0;
    wait_pos(1, 19, 100);
    delay = 24'd10;
    wait_pos(2, 19, 100);
    en = 1'b0;
    wait_idle(10);
    repeat (3) step();

    // 4) D=0: rf_out with frame_start
    period = 24'd100; delay = 24'd0; high = 24'd5;
    en = 1'b1; m_frame = 0;
    wait_pos(1, 50, 200);
    en = 1'b0;
    wait_idle(200);
    step();

    // 5) legality boundaries, 24-bit wrap of D+H+GAP, short periods
    run_one(24'd50, 24'hFFFFFE, 24'd10);
    run_one(24'd30, 24'd20, 24'd5);
    run_one(24'd30, 24'd21, 24'd5);
    run_one(24'd30, 24'd5,  24'd0);
    run_one(24'd3,  24'd0,  24'd1);
    run_one(24'd0,  24'd0,  24'd0);
    run_one(24'd4,  24'd0,  24'd1);
    run_one(24'd10, 24'd2,  24'd3);

    // 6) en dropped mid-frame, reasserted during the final cycle
    period = 24'd20; delay = 24'd3; high = 24'd2;
    en = 1'b1; m_frame = 0;
    wait_pos(1, 5, 50);
    en = 1'b0;
    wait_pos(1, 19, 50);
    en = 1'b1;
    wait_pos(2, 19, 50);
    en = 1'b0;
    wait_idle(10);
    step();

    // 7) async reset mid-HIGH at cnt 15
    period = 24'd100; delay = 24'd10; high = 24'd20;
    en = 1'b1; m_frame = 0;
    wait_pos(1, 15, 200);
    total++;
    assert (rf_out === 1'b1) else begin
      bad++;
      $error("FAIL rf_high_before_rst obs=%b exp=1", rf_out);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    assert ({frame_start, busy, rf_out, fsm_rst, sh_en, cfg_err} === 6'b0) else begin
      bad++;
      $error("FAIL async_rst obs=%b exp=000000",
             {frame_start, busy, rf_out, fsm_rst, sh_en, cfg_err});
    end
    m_active = 1'b0; m_pos = 0; m_err = 1'b0; m_legal = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    m_frame = 0;
    wait_pos(1, 99, 200);
    en = 1'b0;
    wait_idle(10);
    step();

    // 8) period 100 -> 200 changed at cnt 50
    period = 24'd100; delay = 24'd10; high = 24'd5;
    en = 1'b1; m_frame = 0;
    wait_pos(1, 50, 200);
    period = 24'd200;
    wait_pos(2, 100, 400);
    en = 1'b0;
    wait_idle(200);
    step();

    // 9) randomized configs, en toggling, occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) en = ~en;
      if ($urandom_range(0, 3) == 0) begin
        period = CNT_W'($urandom_range(0, 40));
        delay  = CNT_W'($urandom_range(0, 30));
        high   = CNT_W'($urandom_range(0, 10));
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;
    en  = 1'b0;
    wait_idle(100);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
